// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_pkg;

    // Active-low common-anode segment codes: bit 7 = dp, bits 6:0 = g..a.
    localparam logic [7:0] ZER = 8'hC0;
    localparam logic [7:0] ONE = 8'hF9;
    localparam logic [7:0] TWO = 8'hA4;
    localparam logic [7:0] THR = 8'hB0;
    localparam logic [7:0] FOU = 8'h99;
    localparam logic [7:0] FIV = 8'h92;
    localparam logic [7:0] SIX = 8'h82;
    localparam logic [7:0] SEV = 8'hF8;
    localparam logic [7:0] EIG = 8'h80;
    localparam logic [7:0] NIN = 8'h90;
    localparam logic [7:0] A   = 8'h88;
    localparam logic [7:0] B   = 8'h83;
    localparam logic [7:0] C   = 8'hC6;
    localparam logic [7:0] D   = 8'hA1;
    localparam logic [7:0] E   = 8'h86;
    localparam logic [7:0] F   = 8'h8E;

    // All segments and the decimal point off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Position of the decimal point in a segment code.
    localparam int DP_BIT = 7;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble plus decimal point to active-low common-anode segment code.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table lookup, then pull the dp segment low (lit) when requested.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = ZER;
            4'h1: seg = ONE;
            4'h2: seg = TWO;
            4'h3: seg = THR;
            4'h4: seg = FOU;
            4'h5: seg = FIV;
            4'h6: seg = SIX;
            4'h7: seg = SEV;
            4'h8: seg = EIG;
            4'h9: seg = NIN;
            4'hA: seg = A;
            4'hB: seg = B;
            4'hC: seg = C;
            4'hD: seg = D;
            4'hE: seg = E;
            4'hF: seg = F;
            default: seg = SEG_BLANK;
        endcase
        if (dp) begin
            seg[DP_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver with dead time, blanking, frame-aligned load; optional blink via SEG_BLINK_EN.
// Latency: dig/sel/load_ack/frame_start registered, one cycle behind counter state; load visible from next frame's digit 0.
// Backpressure: none; load is a strobe, last load before a frame boundary wins and yields a single load_ack.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int SCAN_CNT  = 50000,
    parameter int DEAD_CYC  = 2,
    parameter int BLINK_CNT = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    output logic                  load_ack,
    output logic                  frame_start,
    output logic [7:0]            dig,
    output logic [DIGITS-1:0]     sel
);

    localparam int SCAN_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CNT - 1);
    localparam logic [SCAN_W-1:0] DEAD_END  = SCAN_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    idx;
    logic                slot_end;
    logic                frame_end;

    logic                pending;
    logic [4*DIGITS-1:0] hex_pend,   hex_act;
    logic [DIGITS-1:0]   dp_pend,    dp_act;
    logic [DIGITS-1:0]   blank_pend, blank_act;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [DIGITS-1:0]   sel_nxt;
    logic [7:0]          seg_code;
    logic                blink_phase;
    logic                blink_dark;

    assign slot_end  = (scan_cnt == SCAN_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Slot counter and digit index; index advances on each slot's last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (slot_end) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BLINK_W = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CNT - 1);

    logic [BLINK_W-1:0]  blink_cnt;
    logic [DIGITS-1:0]   blink_pend, blink_act;
    logic                cur_blink;

    // Free-running blink timer; phase flips every BLINK_CNT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_dark = cur_blink & blink_phase;
`else
    logic unused_blink;
    assign unused_blink = ^blink_in;
    assign blink_phase  = 1'b0;
    assign blink_dark   = blink_phase;
`endif

    // Pending/active double buffer: commit only at the frame boundary so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            hex_pend   <= '0;
            dp_pend    <= '0;
            blank_pend <= '0;
            hex_act    <= '0;
            dp_act     <= '0;
            blank_act  <= '0;
            load_ack   <= 1'b0;
`ifdef SEG_BLINK_EN
            blink_pend <= '0;
            blink_act  <= '0;
`endif
        end else begin
            load_ack <= 1'b0;
            if (load) begin
                hex_pend   <= hex_in;
                dp_pend    <= dp_in;
                blank_pend <= blank_in;
`ifdef SEG_BLINK_EN
                blink_pend <= blink_in;
`endif
            end
            if (frame_end) begin
                pending  <= 1'b0;
                load_ack <= load | pending;
                // A load landing on the boundary bypasses the pending stage.
                if (load) begin
                    hex_act   <= hex_in;
                    dp_act    <= dp_in;
                    blank_act <= blank_in;
`ifdef SEG_BLINK_EN
                    blink_act <= blink_in;
`endif
                end else if (pending) begin
                    hex_act   <= hex_pend;
                    dp_act    <= dp_pend;
                    blank_act <= blank_pend;
`ifdef SEG_BLINK_EN
                    blink_act <= blink_pend;
`endif
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Pick the current digit's fields and build its one-cold select.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        sel_nxt   = '1;
`ifdef SEG_BLINK_EN
        cur_blink = 1'b0;
`endif
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib    = hex_act[4*k +: 4];
                cur_dp     = dp_act[k];
                cur_blank  = blank_act[k];
                sel_nxt[k] = 1'b0;
`ifdef SEG_BLINK_EN
                cur_blink  = blink_act[k];
`endif
            end
        end
    end

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg    (seg_code)
    );

    // Registered pin drive; everything dark during the dead time at the head of each slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= '1;
            dig         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if (scan_cnt < DEAD_END) begin
                sel <= '1;
                dig <= SEG_BLANK;
            end else begin
                sel <= sel_nxt;
                dig <= (cur_blank || blink_dark) ? SEG_BLANK : seg_code;
            end
        end
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed seven-segment display driver for common-anode LED digit arrays. It takes a packed hex word from upstream logic and time-multiplexes it across `DIGITS` digit selects, with ghost-suppression dead time, per-digit decimal point and blanking, and optional per-digit blinking. A load handshake commits new data only on frame boundaries, so no torn frames are displayed. It replaces fixed six-digit display tops and sits between application counters/registers and the board's `dig`/`sel` pins.

## Interface
- `DIGITS`, 6: number of digits; range 1..16.
- `SCAN_CNT`, 50000: clock cycles per digit slot; minimum 2.
- `DEAD_CYC`, 2: blanked cycles at the start of each slot; must be < `SCAN_CNT`.
- `BLINK_CNT`, 25000000: cycles per blink half-period (500 ms at 50 MHz).

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `load`  in  1  single-cycle strobe; captures `hex_in`, `dp_in`, `blank_in`, `blink_in`.
- `hex_in`  in  4*DIGITS  nibble k is shown on digit k.
- `dp_in`  in  DIGITS  decimal point on, per digit.
- `blank_in`  in  DIGITS  digit fully dark, per digit.
- `blink_in`  in  DIGITS  digit blinks, per digit.
- `load_ack`  out  1  one-cycle pulse when captured data becomes active.
- `frame_start`  out  1  one-cycle pulse in the first cycle of digit 0's slot.
- `dig`  out  8  segments, active-low; bit 7 = dp, bits 6:0 = g..a.
- `sel`  out  DIGITS  digit select, active-low.

## Operation
- Slot counter `scan_cnt` counts 0..SCAN_CNT-1. At terminal count, digit index `idx` advances, wrapping DIGITS-1 -> 0.
- Frame boundary is the cycle with `idx`==DIGITS-1 and `scan_cnt`==SCAN_CNT-1.
- Load: `load` writes the pending register and sets `pending`. A second load before commit overwrites pending; last load wins and only one `load_ack` is issued. At the frame boundary, pending is copied to active, `pending` clears, and `load_ack` pulses. A `load` coinciding with the boundary cycle commits its own data directly.
- Segment decode uses active-low common-anode codes: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. If the dp bit is set, bit 7 is cleared.
- Dead time: while `scan_cnt` < `DEAD_CYC`, `sel` is all ones and `dig` is 8'hFF.
- Otherwise `sel` = ~(1<<idx). `dig` is 8'hFF if `blank[idx]` is set or the blink condition holds; else it is the decoded code.
- Reset: `sel` all ones, `dig` 8'hFF, `load_ack` 0, `frame_start` 0, idx 0, counters 0, active and pending data 0, blink phase 0.
- Reset asserted mid-frame: outputs go dark immediately and asynchronously. Any pending load is discarded.

## Timing
- `dig`, `sel`, `load_ack` and `frame_start` are all registered. Each lags the counter state it reflects by 1 cycle.
- After `rst_n` rises, `sel[0]` first goes low in cycle DEAD_CYC+1 (counting the first active edge as cycle 0).
- Frame length is DIGITS*SCAN_CNT cycles.
- `load_ack` appears 1 cycle after the committing boundary edge, coincident with `frame_start`. New data is therefore visible starting with digit 0.
- Worst-case load-to-display latency is DIGITS*SCAN_CNT+1 cycles.

## Configuration
- `SEG_BLINK_EN` defined: a blink counter runs 0..BLINK_CNT-1 and toggles `blink_phase` at terminal count. A digit is blanked when `blink[idx]` && `blink_phase`.
- `SEG_BLINK_EN` undefined: the blink counter is not built, `blink_in` is ignored, and `blink_phase` is constant 0.

## Structure
- Shared package `seg_pkg` holds:
  - Segment constants ZER, ONE, TWO, THR, FOU, FIV, SIX, SEV, EIG, NIN, A, B, C, D, E, F (8-bit, active-low).
  - `SEG_BLANK` = 8'hFF.
- One combinational sub-module, `seg_hex_decode`: a 4-bit nibble plus dp in, 8-bit segment code out.
- Counters, load/commit logic and output registers live in `seg_scan_mux`.

## Test plan
Bench parameters: DIGITS=6, SCAN_CNT=10, DEAD_CYC=2, BLINK_CNT=100.

- **Reset and first frame:** release reset, no load. `sel` is 6'h3F for cycles 0–2, then 6'h3E with `dig`=C0 for 8 cycles. `frame_start` pulses every 60 cycles.
- **Commit:** load `hex_in`=24'h0A5F31 with `dp_in`=6'b000100 mid-frame. No change until the boundary, then `load_ack` and `frame_start` fire together. Digits 0..5 show F9, B0, 0E (8E with dp), 92, 88, C0.
- **Boundary coincidence and overwrite:** two loads in one frame (24'h111111 then 24'h222222) give a single `load_ack` and display A4 only. A load on the exact boundary cycle commits in the same frame.
- **Blank and blink:** `blank_in`=6'b000001 keeps digit 0 at `dig`=FF. With `SEG_BLINK_EN`, `blink_in`=6'b000010 darkens digit 1 on alternate 100-cycle windows. Without the macro, digit 1 is never darkened.
- **Reset mid-frame:** assert `rst_n`=0 during digit 3 with a load pending. `sel` goes 6'h3F and `dig` FF asynchronously. After release, `dig`=C0 on all digits and no `load_ack` occurs.
